// File: rtl/game_status.sv
// Game status tracker: score, lives, wave and play-phase sequencing
// (playing, respawn invulnerability, between-wave pause, game over).
module game_status #(
  parameter int unsigned START_LIVES    = 3,
  parameter int unsigned MAX_LIVES      = 5,
  parameter int unsigned RESPAWN_FRAMES = 90,
  parameter int unsigned PAUSE_FRAMES   = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_playing,
  input  logic        frame_tick,
  input  logic        alien_hit,
  input  logic [3:0]  alien_points,
  input  logic        player_hit,
  input  logic        aliens_landed,
  input  logic        wave_cleared,
  output logic        finished,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic [3:0]  wave,
  output logic        invuln,
  output logic        paused
);

  localparam int unsigned SCORE_W = 16;
  localparam int unsigned SUM_W   = SCORE_W + 1;
  localparam int unsigned LIVES_W = 3;
  localparam int unsigned WAVE_W  = 4;
  localparam int unsigned PTS_W   = 4;
  localparam int unsigned WAVE_MAX = 15;
  localparam int unsigned CNT_MAX =
    (RESPAWN_FRAMES > PAUSE_FRAMES) ? RESPAWN_FRAMES : PAUSE_FRAMES;
  localparam int unsigned CNT_W = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PLAYING    = 3'd1,
    ST_RESPAWN    = 3'd2,
    ST_WAVE_PAUSE = 3'd3,
    ST_OVER       = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     counter_q, counter_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [WAVE_W-1:0]    wave_q, wave_d;
  logic                 finished_q, invuln_q, paused_q;
  logic [SUM_W-1:0]     sum_c;
  logic [SCORE_W-1:0]   score_add_c;

  // Saturating score add: carry out of the 16-bit sum pins the score at all-ones.
  assign sum_c       = {1'b0, score_q} + SUM_W'(alien_points[PTS_W-1:0]);
  assign score_add_c = sum_c[SCORE_W] ? {SCORE_W{1'b1}} : sum_c[SCORE_W-1:0];

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    score_d   = score_q;
    lives_d   = lives_q;
    wave_d    = wave_q;
    if (start) begin
      state_d   = ST_PLAYING;
      counter_d = '0;
      score_d   = '0;
      lives_d   = LIVES_W'(START_LIVES);
      wave_d    = WAVE_W'(1);
    end else if (is_playing) begin
      case (state_q)
        ST_PLAYING: begin
          if (alien_hit) score_d = score_add_c;
          if (aliens_landed) begin
            state_d = ST_OVER;
            lives_d = '0;
          end else if (player_hit) begin
            if (lives_q <= LIVES_W'(1)) begin
              state_d = ST_OVER;
              lives_d = '0;
            end else begin
              state_d   = ST_RESPAWN;
              lives_d   = lives_q - LIVES_W'(1);
              counter_d = CNT_W'(RESPAWN_FRAMES);
            end
          end else if (wave_cleared) begin
            state_d   = ST_WAVE_PAUSE;
            counter_d = CNT_W'(PAUSE_FRAMES);
            if (wave_q < WAVE_W'(WAVE_MAX)) wave_d = wave_q + WAVE_W'(1);
            if (lives_q < LIVES_W'(MAX_LIVES)) lives_d = lives_q + LIVES_W'(1);
          end
        end
        ST_RESPAWN: begin
          if (alien_hit) score_d = score_add_c;
          if (aliens_landed) begin
            state_d = ST_OVER;
            lives_d = '0;
          end else if (frame_tick) begin
            if (counter_q <= CNT_W'(1)) begin
              state_d   = ST_PLAYING;
              counter_d = '0;
            end else begin
              counter_d = counter_q - CNT_W'(1);
            end
          end
        end
        ST_WAVE_PAUSE: begin
          if (frame_tick) begin
            if (counter_q <= CNT_W'(1)) begin
              state_d   = ST_PLAYING;
              counter_d = '0;
            end else begin
              counter_d = counter_q - CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      counter_q  <= '0;
      score_q    <= '0;
      lives_q    <= '0;
      wave_q     <= '0;
      finished_q <= 1'b0;
      invuln_q   <= 1'b0;
      paused_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      wave_q     <= wave_d;
      finished_q <= (state_d == ST_OVER);
      invuln_q   <= (state_d == ST_RESPAWN);
      paused_q   <= (state_d == ST_WAVE_PAUSE);
    end
  end

  assign finished = finished_q;
  assign score    = score_q;
  assign lives    = lives_q;
  assign wave     = wave_q;
  assign invuln   = invuln_q;
  assign paused   = paused_q;

endmodule

// File: tb/tb_game_status.sv
// Directed bench for game_status: vector table plus multi-cycle scenarios.
module tb_game_status;

  logic        clk;
  logic        reset;
  logic        start, is_playing, frame_tick, alien_hit;
  logic [3:0]  alien_points;
  logic        player_hit, aliens_landed, wave_cleared;
  logic        finished, invuln, paused;
  logic [15:0] score;
  logic [2:0]  lives;
  logic [3:0]  wave;

  int checks = 0;
  int errors = 0;

  game_status dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_playing   (is_playing),
    .frame_tick   (frame_tick),
    .alien_hit    (alien_hit),
    .alien_points (alien_points),
    .player_hit   (player_hit),
    .aliens_landed(aliens_landed),
    .wave_cleared (wave_cleared),
    .finished     (finished),
    .score        (score),
    .lives        (lives),
    .wave         (wave),
    .invuln       (invuln),
    .paused       (paused)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, pl, ft, ah;
    logic [3:0]  pts;
    logic        ph, al, wc;
    logic        fin;
    logic [15:0] sc;
    logic [2:0]  lv;
    logic [3:0]  wv;
    logic        inv, pa;
  } vec_t;

  function automatic vec_t mk(input logic st, pl, ft, ah, input logic [3:0] pts,
                              input logic ph, al, wc, fin, input logic [15:0] sc,
                              input logic [2:0] lv, input logic [3:0] wv,
                              input logic inv, pa);
    vec_t v;
    v.st = st; v.pl = pl; v.ft = ft; v.ah = ah; v.pts = pts;
    v.ph = ph; v.al = al; v.wc = wc; v.fin = fin; v.sc = sc;
    v.lv = lv; v.wv = wv; v.inv = inv; v.pa = pa;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic fin, input logic [15:0] sc,
                         input logic [2:0] lv, input logic [3:0] wv,
                         input logic inv, input logic pa);
    chk({name, ".finished"}, int'(finished), int'(fin));
    chk({name, ".score"},    int'(score),    int'(sc));
    chk({name, ".lives"},    int'(lives),    int'(lv));
    chk({name, ".wave"},     int'(wave),     int'(wv));
    chk({name, ".invuln"},   int'(invuln),   int'(inv));
    chk({name, ".paused"},   int'(paused),   int'(pa));
  endtask

  // One clock with the given inputs; returns at the following falling edge.
  task automatic cyc(input logic st, pl, ft, ah, input logic [3:0] pts,
                     input logic ph, al, wc);
    start = st; is_playing = pl; frame_tick = ft; alien_hit = ah;
    alien_points = pts; player_hit = ph; aliens_landed = al; wave_cleared = wc;
    @(posedge clk);
    @(negedge clk);
    start = 0; is_playing = 1; frame_tick = 0; alien_hit = 0;
    alien_points = 0; player_hit = 0; aliens_landed = 0; wave_cleared = 0;
  endtask

  task automatic ticks(input int n, input logic pl);
    for (int i = 0; i < n; i++) cyc(0, pl, 1, 0, 4'd0, 0, 0, 0);
  endtask

  vec_t vecs[13];

  initial begin
    clk = 0; reset = 0;
    start = 0; is_playing = 1; frame_tick = 0; alien_hit = 0;
    alien_points = 0; player_hit = 0; aliens_landed = 0; wave_cleared = 0;
    #1;
    chk_all("reset", 0, 16'd0, 3'd0, 4'd0, 0, 0);
    @(negedge clk);
    reset = 1;

    //             st pl ft ah pts   ph al wc  fin score lv wv inv pa
    vecs[0]  = mk(0, 1, 1, 1, 4'd5, 1, 1, 1,  0, 16'd0,  3'd0, 4'd0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 4'd0, 0, 0, 0,  0, 16'd0,  3'd3, 4'd1, 0, 0);
    vecs[2]  = mk(0, 1, 0, 1, 4'd10,0, 0, 0,  0, 16'd10, 3'd3, 4'd1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 1, 4'd7, 1, 0, 1,  0, 16'd10, 3'd3, 4'd1, 0, 0);
    vecs[4]  = mk(0, 1, 0, 1, 4'd4, 1, 0, 1,  0, 16'd14, 3'd2, 4'd1, 1, 0);
    vecs[5]  = mk(0, 1, 0, 1, 4'd1, 1, 0, 1,  0, 16'd15, 3'd2, 4'd1, 1, 0);
    vecs[6]  = mk(1, 1, 0, 1, 4'd9, 1, 1, 0,  0, 16'd0,  3'd3, 4'd1, 0, 0);
    vecs[7]  = mk(0, 1, 0, 0, 4'd0, 0, 0, 1,  0, 16'd0,  3'd4, 4'd2, 0, 1);
    vecs[8]  = mk(0, 1, 0, 1, 4'd5, 1, 1, 1,  0, 16'd0,  3'd4, 4'd2, 0, 1);
    vecs[9]  = mk(1, 1, 0, 0, 4'd0, 0, 0, 0,  0, 16'd0,  3'd3, 4'd1, 0, 0);
    vecs[10] = mk(0, 1, 0, 1, 4'd6, 1, 1, 1,  1, 16'd6,  3'd0, 4'd1, 0, 0);
    vecs[11] = mk(0, 1, 1, 1, 4'd5, 1, 1, 1,  1, 16'd6,  3'd0, 4'd1, 0, 0);
    vecs[12] = mk(1, 1, 0, 0, 4'd0, 0, 0, 0,  0, 16'd0,  3'd3, 4'd1, 0, 0);

    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].st, vecs[i].pl, vecs[i].ft, vecs[i].ah, vecs[i].pts,
          vecs[i].ph, vecs[i].al, vecs[i].wc);
      chk_all($sformatf("vec%0d", i), vecs[i].fin, vecs[i].sc, vecs[i].lv,
              vecs[i].wv, vecs[i].inv, vecs[i].pa);
    end

    // Respawn: second hit ignored, invulnerability lasts exactly 90 ticks
    cyc(1, 1, 0, 0, 4'd0, 0, 0, 0);
    cyc(0, 1, 0, 0, 4'd0, 1, 0, 0);
    chk_all("resp_hit", 0, 16'd0, 3'd2, 4'd1, 1, 0);
    cyc(0, 1, 0, 0, 4'd0, 1, 0, 0);
    chk("resp_hit2.lives", int'(lives), 2);
    ticks(89, 1);
    chk("resp_89.invuln", int'(invuln), 1);
    ticks(1, 1);
    chk("resp_90.invuln", int'(invuln), 0);

    // Frozen respawn: counter held through 200 ticks, landing ignored
    cyc(0, 1, 0, 0, 4'd0, 1, 0, 0);
    ticks(10, 1);
    ticks(200, 0);
    cyc(0, 0, 1, 0, 4'd0, 0, 1, 0);
    chk_all("frozen", 0, 16'd0, 3'd1, 4'd1, 1, 0);
    ticks(79, 1);
    chk("frozen_79.invuln", int'(invuln), 1);
    ticks(1, 1);
    chk("frozen_80.invuln", int'(invuln), 0);

    // Last life: player_hit beats wave_cleared
    cyc(0, 1, 0, 0, 4'd0, 1, 1'b0, 1);
    chk_all("lastlife", 1, 16'd0, 3'd0, 4'd1, 0, 0);
    cyc(1, 1, 0, 0, 4'd0, 0, 0, 0);
    chk_all("restart", 0, 16'd0, 3'd3, 4'd1, 0, 0);

    // Wave and lives saturation through repeated clears
    for (int w = 2; w <= 15; w++) begin
      cyc(0, 1, 0, 0, 4'd0, 0, 0, 1);
      if (w == 2) chk_all("wave2", 0, 16'd0, 3'd4, 4'd2, 0, 1);
      if (w < 15) ticks(120, 1);
    end
    ticks(119, 1);
    chk("pause_119.paused", int'(paused), 1);
    ticks(1, 1);
    chk_all("pause_120", 0, 16'd0, 3'd5, 4'd15, 0, 0);
    cyc(0, 1, 0, 0, 4'd0, 0, 0, 1);
    chk_all("wave_sat", 0, 16'd0, 3'd5, 4'd15, 0, 1);
    cyc(0, 1, 0, 1, 4'd9, 0, 0, 0);
    chk("pause_hit.score", int'(score), 0);

    // Score saturation at 16'hFFFF
    cyc(1, 1, 0, 0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 4368; i++) cyc(0, 1, 0, 1, 4'd15, 0, 0, 0);
    cyc(0, 1, 0, 1, 4'd8, 0, 0, 0);
    chk("score_fff8", int'(score), 32'hFFF8);
    cyc(0, 1, 0, 1, 4'd10, 0, 0, 0);
    chk("score_sat", int'(score), 32'hFFFF);
    cyc(0, 1, 0, 1, 4'd15, 0, 0, 0);
    chk("score_hold", int'(score), 32'hFFFF);

    // Asynchronous reset mid-game, then IDLE until start
    cyc(0, 1, 0, 0, 4'd0, 1, 0, 0);
    #2 reset = 0;
    #1;
    chk_all("async_rst", 0, 16'd0, 3'd0, 4'd0, 0, 0);
    @(negedge clk);
    reset = 1;
    cyc(0, 1, 1, 1, 4'd3, 1, 0, 1);
    chk_all("post_rst_idle", 0, 16'd0, 3'd0, 4'd0, 0, 0);
    cyc(1, 1, 0, 0, 4'd0, 0, 0, 0);
    chk_all("post_rst_start", 0, 16'd0, 3'd3, 4'd1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
